gate_truth_sequencer: RTL
=========================

Name: gate_truth_sequencer

Overview:
Stimulus and check stage that sits directly upstream of a 2-input gate-under-test such as gate_and. It drives the gate's two inputs and reads back the gate output.
- On start, it walks all four input combinations in Gray order 00,01,11,10. This is the same order the AND bench applies by hand.
- After a settle delay it samples the gate output and compares it to a 4-bit expected truth table.
- It reports pass/fail, a per-combination fail vector and an error count.
- It replaces hand-written initial-block stimulus with a reusable, synthesizable self-checker.

Parameters:
SETTLE_CYCLES, 2, cycles each combination is held before sampling; legal range >=1.
REPEAT, 1, number of full 4-combination passes per run; legal range >=1.
CNT_W, 4, width of err_count.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  run request; accepted only in IDLE.
expect_tt  in  4  expected truth table; bit index = {inp1,inp2}; latched on start.
dut_out  in  1  output of the gate-under-test.
drv_inp1  out  1  drives gate inp1.
drv_inp2  out  1  drives gate inp2.
busy  out  1  high from the cycle after start is accepted through the DONE cycle.
done  out  1  one-cycle pulse at end of run.
pass  out  1  1 when err_count==0 at end of run; held until next accepted start.
err_count  out  CNT_W  mismatch count, saturating at 2^CNT_W-1.
fail_vec  out  4  sticky per-combination mismatch flags, index {inp1,inp2}.

Behaviour:
Reset:
- While rst is high, all outputs are 0 immediately (asynchronous): drv=00, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
- State goes to IDLE, step=0, pass_idx=0, settle counter=0.
- Deasserting rst mid-run does not resume the run; a new start is required.

FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1:
  - Latch expect_tt.
  - Clear err_count, fail_vec and pass.
  - Set step=0, drv=00, settle counter=SETTLE_CYCLES-1.
  - Go to SETTLE.
- SETTLE:
  - Hold drv.
  - Decrement the counter; when it is 0, go to SAMPLE.
  - The state therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - mismatch = dut_out != expected bit at index {drv_inp1,drv_inp2}.
  - On mismatch: err_count+1 (saturating) and set the corresponding fail_vec bit.
  - If step<3: step+1, drive the next Gray code, reload the counter, go to SETTLE.
  - If step==3 and pass_idx<REPEAT-1: pass_idx+1, step=0, drv=00, go to SETTLE.
  - Otherwise go to DONE with drv=00.
- DONE (one cycle):
  - done=1.
  - pass=(err_count==0), registered on DONE entry so it is valid in the same cycle as done.
  - Next state is IDLE.

Gray sequence by step: 0→00, 1→01, 2→11, 3→10 ({inp1,inp2}).

Timing:
- Each combination occupies SETTLE_CYCLES+1 cycles.
- done is high in the cycle beginning REPEAT*4*(SETTLE_CYCLES+1) rising edges after the edge that accepted start. With defaults this is 12.
- drv outputs change only on clock edges and are registered.

Boundary conditions:
- start while busy, including in the DONE cycle, is ignored.
- start held high continuously gives back-to-back runs, with exactly one IDLE cycle between DONE and the next SETTLE.
- expect_tt changing mid-run has no effect.
- err_count never wraps; it holds at its maximum.
- busy=0 in IDLE only.

Decomposition:
Package gate_test_pkg contains:
- FSM state enum.
- Gray step-to-inputs constant table.
- Truth-table constants: TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111.

One sub-module, settle_timer:
- Ports: load, load value, decrement enable.
- Output: zero flag.
- Reset asynchronous active-high.

Test Plan:
1. Golden run: TT_AND, real gate_and wired, defaults.
   - drv holds 00,01,11,10 for 3 cycles each.
   - done at edge 12; pass=1, err_count=0, fail_vec=0000.
2. Stuck-at-0 DUT, TT_AND.
   - err_count=1, fail_vec=1000, pass=0.
3. TT_OR against gate_and.
   - Mismatches at 01 and 10: err_count=2, fail_vec=0110, pass=0.
4. Handshake.
   - start pulses while busy and during the DONE cycle produce a single done.
   - start held high gives a second run starting exactly one IDLE cycle after DONE, with err_count and fail_vec cleared at acceptance.
5. Reset mid-run: rst asserted during step 2 SETTLE.
   - All outputs are 0 in the same cycle.
   - After release, busy stays 0 until start.
   - The next golden run passes.
6. Saturation: REPEAT=3, CNT_W=3, stuck-at-1 DUT, TT_AND.
   - 9 mismatches saturate err_count at 7.
   - fail_vec=0111; done at edge 36.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate truth-table sequencer: FSM encoding,
// Gray stimulus order and reference truth tables for common 2-input gates.
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Entry i is the {inp1,inp2} pair driven at step i: 00, 01, 11, 10.
  localparam logic [3:0][1:0] GRAY_TBL = {2'b10, 2'b11, 2'b01, 2'b00};

  // Bit index of each table is {inp1,inp2}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_truth_sequencer_if.sv
// Control, stimulus and result signals between the truth-table sequencer
// and the block that starts runs and hosts the gate under test.
interface gate_truth_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [3:0]       expect_tt;
    logic             dut_out;
    logic             drv_inp1;
    logic             drv_inp2;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [3:0]       fail_vec;

    modport master (
        output start, expect_tt, dut_out,
        input  drv_inp1, drv_inp2, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, expect_tt, dut_out,
        output drv_inp1, drv_inp2, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_truth_sequencer_settle_timer.sv
// Loadable down-counter that measures how long each input combination is held
// before the gate output is sampled.
module settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/gate_truth_sequencer.sv
// Walks a 2-input gate through all four input pairs in Gray order, samples its
// output after a settle delay and scores it against an expected truth table.
module gate_truth_sequencer
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int REPEAT        = 1,
    parameter int CNT_W         = 4
) (
    input logic                   clk,
    input logic                   rst,
    gate_truth_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SETTLE = ST_SETTLE;
    localparam logic [1:0] S_SAMPLE = ST_SAMPLE;
    localparam logic [1:0] S_DONE   = ST_DONE;

    localparam int              TW        = $clog2(SETTLE_CYCLES + 1);
    localparam int              PW        = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [PW-1:0]   PASS_LAST = PW'(REPEAT - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

    logic [1:0]       state;
    logic [1:0]       step;
    logic [PW-1:0]    pass_idx;
    logic [1:0]       drv;
    logic [3:0]       tt_q;
    logic [CNT_W-1:0] err_q;
    logic [3:0]       fail_q;
    logic             pass_q;

    logic             accept;
    logic             last_sample;
    logic             mismatch;
    logic [CNT_W-1:0] err_next;
    logic             tmr_load;
    logic             tmr_zero;

    assign accept      = (state == S_IDLE) && bus.start;
    assign last_sample = (step == 2'd3) && (pass_idx == PASS_LAST);
    assign mismatch    = (bus.dut_out != tt_q[drv]);
    assign err_next    = (mismatch && err_q != ERR_MAX) ? err_q + CNT_W'(1) : err_q;
    assign tmr_load    = accept || ((state == S_SAMPLE) && !last_sample);

    settle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TW'(SETTLE_CYCLES - 1)),
        .dec      (state == S_SETTLE),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            step     <= '0;
            pass_idx <= '0;
            drv      <= '0;
            tt_q     <= '0;
            err_q    <= '0;
            fail_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        tt_q     <= bus.expect_tt;
                        err_q    <= '0;
                        fail_q   <= '0;
                        pass_q   <= 1'b0;
                        step     <= '0;
                        pass_idx <= '0;
                        drv      <= GRAY_TBL[0];
                        state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (tmr_zero)
                        state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    err_q <= err_next;
                    if (mismatch)
                        fail_q[drv] <= 1'b1;
                    if (step != 2'd3) begin
                        step  <= step + 2'd1;
                        drv   <= GRAY_TBL[step + 2'd1];
                        state <= S_SETTLE;
                    end else if (pass_idx != PASS_LAST) begin
                        pass_idx <= pass_idx + PW'(1);
                        step     <= '0;
                        drv      <= GRAY_TBL[0];
                        state    <= S_SETTLE;
                    end else begin
                        // Verdict uses err_next so the final sample counts.
                        drv    <= GRAY_TBL[0];
                        pass_q <= (err_next == '0);
                        state  <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.drv_inp1  = drv[1];
    assign bus.drv_inp2  = drv[0];
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;
endmodule
